// File: rtl/sq_root_carry_adder_pkg.sv
// Shared definitions for the square-root carry-select adder: group-size rule,
// group geometry helpers and reset values.
package sq_root_carry_adder_pkg;

  localparam int FIRST_GROUP_SIZE = 2;
  localparam int MAX_WIDTH        = 16;

  localparam logic RST_SUM_BIT = 1'b0;
  localparam logic RST_C_OUT   = 1'b0;
  localparam logic RST_OVF     = 1'b0;

  // Sizes run 2,2,3,4,5,...: the size grows by one after every group from group 1 on.
  function automatic int group_start(input int width, input int idx);
    int start;
    int size;
    start = 0;
    size  = FIRST_GROUP_SIZE;
    for (int k = 0; k < idx; k++) begin
      start = start + size;
      if (k >= 1) size = size + 1;
    end
    if (start > width) start = width;
    return start;
  endfunction

  function automatic int group_count(input int width);
    int n;
    n = 0;
    for (int k = 0; k <= MAX_WIDTH; k++) begin
      if (group_start(width, k) < width) n = k + 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/sq_root_carry_adder_rca.sv
// Ripple-carry block used for every group of the carry-select adder.
module rca_block #(
  parameter int W = 2
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] w_c;

  assign w_c[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ w_c[i];
    assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
  end

  assign cout = w_c[W];

endmodule

// File: rtl/sq_root_carry_adder.sv
// Registered square-root carry-select adder, one result per cycle, 1-cycle latency.
// Optional overflow output enabled by defining SQ_ROOT_CARRY_ADDER_OVF_EN.
module sq_root_carry_adder
  import sq_root_carry_adder_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
`ifdef SQ_ROOT_CARRY_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NG = group_count(WIDTH);

  logic [NG:0]      w_carry;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] r_sum;
  logic             r_c_out;

  assign w_carry[0] = c_in;

  for (genvar g = 0; g < NG; g++) begin : g_grp
    localparam int LO = group_start(WIDTH, g);
    localparam int HI = (g == NG - 1) ? WIDTH - 1 : group_start(WIDTH, g + 1) - 1;
    localparam int SZ = HI - LO + 1;

    if (g == 0) begin : g_first
      rca_block #(.W(SZ)) u_rca (
        .a    (a[HI:LO]),
        .b    (b[HI:LO]),
        .cin  (w_carry[0]),
        .sum  (w_sum[HI:LO]),
        .cout (w_carry[1])
      );
    end else begin : g_sel
      logic [SZ-1:0] w_s0;
      logic [SZ-1:0] w_s1;
      logic          w_c0;
      logic          w_c1;

      rca_block #(.W(SZ)) u_rca0 (
        .a(a[HI:LO]), .b(b[HI:LO]), .cin(1'b0), .sum(w_s0), .cout(w_c0)
      );
      rca_block #(.W(SZ)) u_rca1 (
        .a(a[HI:LO]), .b(b[HI:LO]), .cin(1'b1), .sum(w_s1), .cout(w_c1)
      );

      // Previous group's carry picks which precomputed result is real.
      assign w_sum[HI:LO] = w_carry[g] ? w_s1 : w_s0;
      assign w_carry[g+1] = w_carry[g] ? w_c1 : w_c0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sum   <= {WIDTH{RST_SUM_BIT}};
      r_c_out <= RST_C_OUT;
    end else begin
      r_sum   <= w_sum;
      r_c_out <= w_carry[NG];
    end
  end

  assign sum   = r_sum;
  assign c_out = r_c_out;

`ifdef SQ_ROOT_CARRY_ADDER_OVF_EN
  logic w_c_into_msb;
  logic r_ovf;

  // Carry into the MSB is recovered from the MSB sum bit itself.
  assign w_c_into_msb = a[WIDTH-1] ^ b[WIDTH-1] ^ w_sum[WIDTH-1];

  always_ff @(posedge clk) begin
    if (!rst_n) r_ovf <= RST_OVF;
    else        r_ovf <= w_c_into_msb ^ w_carry[NG];
  end

  assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_sq_root_carry_adder.sv
// Scoreboard bench for sq_root_carry_adder: directed, exhaustive and random operands.
module tb_sq_root_carry_adder;

  localparam int W = 5;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic [W-1:0] sum;
  logic         c_out;
  logic         ovf_obs;

  int n_cmp  = 0;
  int n_fail = 0;
  bit done   = 0;

  // Entry layout: {ovf, c_out, sum}
  logic [W+1:0] exp_q[$];

  sq_root_carry_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
    .sum   (sum),
    .c_out (c_out)
`ifdef SQ_ROOT_CARRY_ADDER_OVF_EN
    ,
    .ovf   (ovf_obs)
`endif
  );

`ifndef SQ_ROOT_CARRY_ADDER_OVF_EN
  assign ovf_obs = 1'b0;
`endif

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain integer arithmetic, unsigned and signed views.
  function automatic logic [W+1:0] model(input int ai, input int bi, input int ci, input bit in_rst);
    int total;
    int sa;
    int sb;
    int s;
    logic ov;
    logic [W+1:0] r;
    if (in_rst) return '0;
    total = ai + bi + ci;
    sa = (ai >= (1 << (W - 1))) ? ai - (1 << W) : ai;
    sb = (bi >= (1 << (W - 1))) ? bi - (1 << W) : bi;
    s  = sa + sb + ci;
    ov = (s > (1 << (W - 1)) - 1) || (s < -(1 << (W - 1)));
    r[W:0] = total[W:0];
    r[W+1] = ov;
    return r;
  endfunction

  // driver: present one operand set for one cycle and record its expectation
  task automatic drive(input int ai, input int bi, input int ci, input bit in_rst);
    rst_n = ~in_rst;
    a     = ai[W-1:0];
    b     = bi[W-1:0];
    c_in  = ci[0];
    exp_q.push_back(model(ai, bi, ci, in_rst));
    @(negedge clk);
  endtask

  // monitor: every rising edge produces exactly one result
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      logic [W+1:0] e;
      e = exp_q.pop_front();
      n_cmp++;
      if ({c_out, sum} !== e[W:0]) begin
        n_fail++;
        $display("FAIL result: got c_out=%0b sum=%b, expected c_out=%0b sum=%b (a=%b b=%b)",
                 c_out, sum, e[W], e[W-1:0], a, b);
      end
`ifdef SQ_ROOT_CARRY_ADDER_OVF_EN
      n_cmp++;
      if (ovf_obs !== e[W+1]) begin
        n_fail++;
        $display("FAIL ovf: got %0b, expected %0b", ovf_obs, e[W+1]);
      end
`endif
    end
  end

  initial begin
    rst_n = 1'b0;
    a     = '0;
    b     = '0;
    c_in  = 1'b0;
    @(negedge clk);

    // reset held with all-ones operands: outputs stay zero
    drive(31, 31, 1, 1'b1);
    drive(31, 31, 1, 1'b1);

    // directed vectors
    drive(5'b00101, 5'b10111, 0, 1'b0);  // 28
    drive(5'b11111, 5'b11111, 1, 1'b0);  // wrap-around
    drive(5'b00011, 5'b00001, 0, 1'b0);  // carry crosses group boundary
    drive(5'b01111, 5'b00001, 0, 1'b0);  // signed overflow
    drive(5'b10000, 5'b10000, 0, 1'b0);  // negative overflow, c_out only
    drive(0, 0, 0, 1'b0);

    // exhaustive, back-to-back, with a one-cycle reset mid-stream
    for (int i = 0; i < (1 << (2 * W + 1)); i++) begin
      if (i == 1000) drive(31, 31, 1, 1'b1);
      drive(i & 31, (i >> W) & 31, (i >> (2 * W)) & 1, 1'b0);
    end

    // random tail, occasional reset
    for (int i = 0; i < 300; i++) begin
      drive($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 1),
            ($urandom_range(0, 49) == 0));
    end

    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    done = 1;
    $finish;
  end

  initial begin
    #1000000;
    if (!done) begin
      $display("FAIL timeout: simulation did not complete, expected completion");
      $fatal(1, "timeout");
    end
  end

endmodule
